axis_pkt_gen: RTL and testbench

AXI-Stream packet transmitter that produces one packet of arithmetic-sequence data per start command. It drives a downstream AXI-Stream slave, such as a register slice or FIFO, honouring `m_tready` backpressure beat by beat. It is the hardware source for stream datapaths and for self-checking loopback setups. An optional inter-frame gap is inserted after every packet.

---
 rtl/axis_gen_pkg.sv | 13 +
 rtl/axis_pkt_gen.sv | 129 ++++++++++++
 tb/tb_axis_pkt_gen.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
package axis_gen_pkg;

   // Width of the inter-frame gap counter; covers IFG values 0..255.
   localparam int unsigned IFG_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet transmitter: one packet of arithmetic-sequence data per
// start command, with optional inter-frame gap before the done pulse.
module axis_pkt_gen #(
   parameter int unsigned DW   = 8,
   parameter int unsigned LW   = 16,
   parameter int unsigned STEP = 2,
   parameter int unsigned IFG  = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] cfg_len,
   input  logic [DW-1:0] cfg_start_val,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready
);
   import axis_gen_pkg::*;

   localparam logic [DW-1:0]    STEP_V   = DW'(STEP);
   localparam logic [IFG_W-1:0] IFG_LAST = (IFG > 0) ? IFG_W'(IFG - 1) : '0;

   state_t           state, state_n;
   logic [LW-1:0]    rem, rem_n;
   logic [DW-1:0]    data_q, data_n;
   logic [IFG_W-1:0] gap_cnt, gap_n;
   logic [DW-1:0]    tdata_n;
   logic             valid_n, last_n, busy_n, done_n;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Next-state logic plus next values of every registered output, so that
   // all outputs come straight from flops.
   always_comb begin
      state_n = state;
      rem_n   = rem;
      data_n  = data_q;
      gap_n   = gap_cnt;
      tdata_n = m_tdata;
      valid_n = m_tvalid;
      last_n  = m_tlast;
      busy_n  = busy;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            if (start && (cfg_len != '0)) begin
               state_n = SEND;
               rem_n   = cfg_len;
               data_n  = cfg_start_val;
               tdata_n = cfg_start_val;
               valid_n = 1'b1;
               last_n  = (cfg_len == LW'(1));
               busy_n  = 1'b1;
            end
         end
         SEND: begin
            // m_tvalid is always 1 in SEND, so m_tready alone marks a handshake.
            if (m_tready) begin
               rem_n  = rem - LW'(1);
               data_n = data_q + STEP_V;
               if (rem == LW'(1)) begin
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  if (IFG > 0) begin
                     state_n = GAP;
                     gap_n   = '0;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                  end
               end else begin
                  tdata_n = data_q + STEP_V;
                  last_n  = (rem == LW'(2));
               end
            end
         end
         GAP: begin
            if (gap_cnt == IFG_LAST) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               gap_n = gap_cnt + IFG_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
   end

   // Datapath and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem      <= '0;
         data_q   <= '0;
         gap_cnt  <= '0;
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         rem      <= rem_n;
         data_q   <= data_n;
         gap_cnt  <= gap_n;
         m_tdata  <= tdata_n;
         m_tvalid <= valid_n;
         m_tlast  <= last_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: two instances (IFG=0 and IFG=3) share
// stimulus and are checked every cycle against a packet-level model, plus
// literal beat/timing expectations for the directed scenarios.
module tb_axis_pkt_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] cfg_len;
   logic [7:0]  cfg_sv;
   logic        tready;

   logic       d0_busy, d0_done, d0_valid, d0_last;
   logic [7:0] d0_data;
   logic       d3_busy, d3_done, d3_valid, d3_last;
   logic [7:0] d3_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   axis_pkt_gen #(.DW(8), .LW(16), .STEP(2), .IFG(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
      .cfg_start_val(cfg_sv), .busy(d0_busy), .done(d0_done),
      .m_tdata(d0_data), .m_tvalid(d0_valid), .m_tlast(d0_last),
      .m_tready(tready));

   axis_pkt_gen #(.DW(8), .LW(16), .STEP(2), .IFG(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
      .cfg_start_val(cfg_sv), .busy(d3_busy), .done(d3_done),
      .m_tdata(d3_data), .m_tvalid(d3_valid), .m_tlast(d3_last),
      .m_tready(tready));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Packet-level model: beat k of a packet carries start + k*STEP (mod 256);
   // after the last accepted beat, IFG idle cycles then a one-cycle done.
   bit       m_send [2];
   int       m_idx  [2];
   int       m_len  [2];
   int       m_gap  [2];
   int       m_sv   [2];
   bit       m_done [2];

   function automatic int ifg_of(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            m_send[i] = 0; m_idx[i] = 0; m_len[i] = 0;
            m_gap[i] = 0; m_sv[i] = 0; m_done[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit dn;
            dn = 0;
            if (m_send[i]) begin
               if (tready) begin
                  if (m_idx[i] == m_len[i] - 1) begin
                     m_send[i] = 0;
                     if (ifg_of(i) > 0) m_gap[i] = ifg_of(i);
                     else dn = 1;
                  end else begin
                     m_idx[i]++;
                  end
               end
            end else if (m_gap[i] > 0) begin
               m_gap[i]--;
               if (m_gap[i] == 0) dn = 1;
            end else if (start && cfg_len != 0) begin
               m_send[i] = 1;
               m_idx[i]  = 0;
               m_len[i]  = int'(cfg_len);
               m_sv[i]   = int'(cfg_sv);
            end
            m_done[i] = dn;
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      logic [7:0] e0, e3;
      e0 = 8'(m_sv[0] + m_idx[0] * 2);
      e3 = 8'(m_sv[1] + m_idx[1] * 2);
      chk("m0_valid", 32'(d0_valid), 32'(m_send[0]));
      chk("m0_busy",  32'(d0_busy),  32'(m_send[0] || m_gap[0] > 0));
      chk("m0_done",  32'(d0_done),  32'(m_done[0]));
      chk("m0_last",  32'(d0_last),  32'(m_send[0] && m_idx[0] == m_len[0] - 1));
      if (m_send[0]) chk("m0_data", 32'(d0_data), 32'(e0));
      chk("m3_valid", 32'(d3_valid), 32'(m_send[1]));
      chk("m3_busy",  32'(d3_busy),  32'(m_send[1] || m_gap[1] > 0));
      chk("m3_done",  32'(d3_done),  32'(m_done[1]));
      chk("m3_last",  32'(d3_last),  32'(m_send[1] && m_idx[1] == m_len[1] - 1));
      if (m_send[1]) chk("m3_data", 32'(d3_data), 32'(e3));
   end

   // Beat capture (data, tlast, cycle) and activity counters for literal checks.
   int q0d[$], q0l[$], q0c[$];
   int q3d[$], q3l[$], q3c[$];
   int v0cnt, d0cnt, v3cnt, d3cnt;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (d0_valid && tready) begin q0d.push_back(int'(d0_data)); q0l.push_back(int'(d0_last)); q0c.push_back(cyc); end
         if (d3_valid && tready) begin q3d.push_back(int'(d3_data)); q3l.push_back(int'(d3_last)); q3c.push_back(cyc); end
         v0cnt += int'(d0_valid); d0cnt += int'(d0_done);
         v3cnt += int'(d3_valid); d3cnt += int'(d3_done);
      end
   end

   int ed[$], el[$];

   task automatic check_caps(input int which, input string nm);
      int n;
      n = (which == 0) ? q0d.size() : q3d.size();
      chk({nm, "_count"}, 32'(n), 32'(ed.size()));
      for (int k = 0; k < ed.size() && k < n; k++) begin
         chk($sformatf("%s_data%0d", nm, k), 32'((which == 0) ? q0d[k] : q3d[k]), 32'(ed[k]));
         chk($sformatf("%s_last%0d", nm, k), 32'((which == 0) ? q0l[k] : q3l[k]), 32'(el[k]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      q0d.delete(); q0l.delete(); q0c.delete();
      q3d.delete(); q3l.delete(); q3c.delete();
      v0cnt = 0; d0cnt = 0; v3cnt = 0; d3cnt = 0;
   endtask

   task automatic launch(input int len, input int sv);
      clear_caps();
      cfg_len = 16'(len);
      cfg_sv  = 8'(sv);
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   task automatic wait_done(input int which, input int budget, input string nm, output int c);
      int found;
      found = 0;
      c = -1;
      for (int n = 0; n < budget && found == 0; n++) begin
         step();
         if (((which == 0) ? d0_done : d3_done) === 1'b1) begin
            found = 1;
            c = cyc;
         end
      end
      if (found == 0) chk({nm, "_timeout"}, 32'(found), 32'(1));
   endtask

   initial begin
      int c0, c1, c2, n;
      bit pat [7];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      rst = 1'b0; start = 1'b0; cfg_len = '0; cfg_sv = '0; tready = 1'b1;
      v0cnt = 0; d0cnt = 0; v3cnt = 0; d3cnt = 0;
      repeat (3) step();

      // Reset state
      chk("rst_valid0", 32'(d0_valid), 0); chk("rst_last0", 32'(d0_last), 0);
      chk("rst_data0", 32'(d0_data), 0);   chk("rst_busy0", 32'(d0_busy), 0);
      chk("rst_done0", 32'(d0_done), 0);   chk("rst_valid3", 32'(d3_valid), 0);
      chk("rst_data3", 32'(d3_data), 0);   chk("rst_busy3", 32'(d3_busy), 0);
      rst = 1'b1;
      repeat (2) step();

      // Basic packet: 0,2,...,18 on consecutive cycles, done right after.
      launch(10, 0);
      wait_done(0, 40, "basic", c0);
      ed = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18};
      el = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      check_caps(0, "basic");
      if (q0c.size() == 10) begin
         chk("basic_consec", 32'(q0c[9] - q0c[0]), 9);
         chk("basic_done_lat", 32'(c0 - q0c[9]), 1);
      end
      repeat (8) step();

      // Backpressure: ready pattern 1,0,0,1,0,1,1 from the first valid cycle.
      launch(4, 0);
      for (int i = 0; i < 7; i++) begin
         tready = pat[i];
         step();
      end
      tready = 1'b1;
      chk("bp_done", 32'(d0_done), 1);
      ed = '{0, 2, 4, 6};
      el = '{0, 0, 0, 1};
      check_caps(0, "bp");
      repeat (8) step();

      // Data wraps modulo 256.
      launch(4, 'hFC);
      wait_done(0, 20, "wrap", c0);
      ed = '{'hFC, 'hFE, 'h00, 'h02};
      el = '{0, 0, 0, 1};
      check_caps(0, "wrap");
      repeat (8) step();

      // Single-beat packet.
      launch(1, 'h55);
      wait_done(0, 20, "len1", c0);
      ed = '{'h55};
      el = '{1};
      check_caps(0, "len1");
      repeat (8) step();

      // Zero-length start is ignored.
      launch(0, 'h77);
      repeat (6) step();
      chk("zero_valid0", 32'(v0cnt), 0); chk("zero_done0", 32'(d0cnt), 0);
      chk("zero_valid3", 32'(v3cnt), 0); chk("zero_done3", 32'(d3cnt), 0);

      // Start pulsed mid-packet is not queued.
      launch(5, 'h10);
      repeat (2) step();
      cfg_len = 16'd3; cfg_sv = 8'h80; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(0, 20, "mid", c0);
      ed = '{'h10, 'h12, 'h14, 'h16, 'h18};
      el = '{0, 0, 0, 0, 1};
      check_caps(0, "mid");
      repeat (6) step();
      clear_caps();
      repeat (6) step();
      chk("mid_no_second0", 32'(v0cnt), 0);
      chk("mid_no_second3", 32'(v3cnt), 0);

      // Back-to-back with IFG=0: start issued in the done cycle.
      launch(2, 'h00);
      wait_done(0, 20, "b2b", c0);
      cfg_len = 16'd2; cfg_sv = 8'h30; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(0, 20, "b2b2", c1);
      ed = '{'h00, 'h02, 'h30, 'h32};
      el = '{0, 1, 0, 1};
      check_caps(0, "b2b");
      if (q0c.size() == 4) chk("b2b_spacing", 32'(q0c[2] - q0c[1]), 2);
      repeat (10) step();

      // IFG=3: each next start issued in the done cycle.
      launch(3, 'h20);
      wait_done(3, 30, "gap1", c0);
      cfg_len = 16'd2; cfg_sv = 8'h90; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(3, 30, "gap2", c1);
      cfg_len = 16'd1; cfg_sv = 8'h40; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(3, 30, "gap3", c2);
      ed = '{'h20, 'h22, 'h24, 'h90, 'h92, 'h40};
      el = '{0, 0, 1, 0, 1, 1};
      check_caps(3, "gap");
      if (q3c.size() == 6) begin
         chk("gap_done_lat", 32'(c0 - q3c[2]), 4);
         chk("gap_spacing1", 32'(q3c[3] - q3c[2]), 5);
         chk("gap_spacing2", 32'(q3c[5] - q3c[4]), 5);
         chk("gap_done_lat3", 32'(c2 - q3c[5]), 4);
      end
      repeat (10) step();

      // Reset mid-packet after beat 2 has been accepted.
      launch(10, 0);
      n = 0;
      while (q0d.size() < 3 && n < 20) begin
         step();
         n++;
      end
      chk("rstmid_reached", 32'(q0d.size() >= 3), 1);
      rst = 1'b0;
      #1;
      chk("rstmid_valid0", 32'(d0_valid), 0); chk("rstmid_last0", 32'(d0_last), 0);
      chk("rstmid_busy0", 32'(d0_busy), 0);   chk("rstmid_valid3", 32'(d3_valid), 0);
      repeat (2) step();
      rst = 1'b1;
      clear_caps();
      repeat (15) step();
      chk("rstmid_no_beats0", 32'(v0cnt), 0); chk("rstmid_no_done0", 32'(d0cnt), 0);
      chk("rstmid_no_beats3", 32'(v3cnt), 0); chk("rstmid_no_done3", 32'(d3cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
